// File: rtl/pipe_hazard_unit.sv
// Hazard detection and pipeline control for a 5-stage MIPS pipeline.
// Tracks which destination registers are in flight in EX and MEM. From that it
// derives the stall/bubble and flush controls, the registered EX forwarding
// selects, and the saturating stall/flush performance counters.
module pipe_hazard_unit #(
  parameter int RA_W     = 5,
  parameter int FWD_EN   = 1,
  parameter int BR_FLUSH = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             redirect,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic FWD_ON  = (FWD_EN != 0);
  localparam logic FLUSH_2 = (BR_FLUSH >= 2);
  localparam logic FLUSH_3 = (BR_FLUSH >= 3);

  // Shadow of the EX and MEM stages. The WB stage is not tracked because the
  // register file is write-first: a WB producer is already visible to ID, so
  // its state could never change any output. MEM's load flag is dropped for
  // the same reason, since it only matters while the load is in EX.
  logic            ex_valid_q, ex_valid_d;
  logic [RA_W-1:0] ex_dst_q, ex_dst_d;
  logic            ex_rw_q, ex_rw_d;
  logic            ex_mr_q, ex_mr_d;
  logic            mem_valid_q, mem_valid_d;
  logic [RA_W-1:0] mem_dst_q, mem_dst_d;
  logic            mem_rw_q, mem_rw_d;

  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic hz, stall, flush_if, flush_id, flush_ex;

  // A source operand depends on a stage when the stage writes a nonzero
  // register that equals the source, and the ID instruction actually reads it.
  function automatic logic src_hit(input logic            v,
                                   input logic            rw,
                                   input logic [RA_W-1:0] dst,
                                   input logic            uses,
                                   input logic [RA_W-1:0] src);
    return v & rw & (dst != '0) & uses & (src == dst);
  endfunction

  // Hazard detection and redirect decode; redirect beats stall.
  always_comb begin
    ex_rs  = src_hit(ex_valid_q,  ex_rw_q,  ex_dst_q,  id_uses_rs, id_rs);
    ex_rt  = src_hit(ex_valid_q,  ex_rw_q,  ex_dst_q,  id_uses_rt, id_rt);
    mem_rs = src_hit(mem_valid_q, mem_rw_q, mem_dst_q, id_uses_rs, id_rs);
    mem_rt = src_hit(mem_valid_q, mem_rw_q, mem_dst_q, id_uses_rt, id_rt);
    if (FWD_ON) hz = id_valid & (ex_rs | ex_rt) & ex_mr_q;
    else        hz = id_valid & (ex_rs | ex_rt | mem_rs | mem_rt);
    // NOTE: rst_n gates the combinational controls so they drop the instant
    // reset is asserted, even while the shadow inputs still show a hazard.
    stall    = rst_n & hz & ~redirect;
    flush_if = rst_n & redirect;
    flush_id = flush_if & FLUSH_2;
    flush_ex = flush_if & FLUSH_3;
  end

  // Next shadow state, forwarding selects and counter values.
  always_comb begin
    // With BR_FLUSH == 1 only the fetched instruction is squashed; the ID
    // instruction still advances, so the IF/ID flush never invalidates S_EX.
    ex_valid_d  = id_valid & ~(stall | flush_id);
    ex_dst_d    = id_dst;
    ex_rw_d     = id_reg_write;
    ex_mr_d     = id_mem_read;
    mem_valid_d = ex_valid_q & ~flush_ex;
    mem_dst_d   = ex_dst_q;
    mem_rw_d    = ex_rw_q;

    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (FWD_ON && !stall && !flush_id) begin
      // The younger producer (EX) takes precedence over MEM.
      if (ex_rs)       fwd_a_d = 2'b10;
      else if (mem_rs) fwd_a_d = 2'b01;
      if (ex_rt)       fwd_b_d = 2'b10;
      else if (mem_rt) fwd_b_d = 2'b01;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_if && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Control state: valid bits, forwarding selects and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values computed above.
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Shadow payload fields.
  // NOTE: payload is qualified by its valid bit everywhere, so it carries no
  // reset; only the valid bits must come out of reset cleared.
  always_ff @(posedge clk) begin
    ex_dst_q  <= ex_dst_d;
    ex_rw_q   <= ex_rw_d;
    ex_mr_q   <= ex_mr_d;
    mem_dst_q <= mem_dst_d;
    mem_rw_q  <= mem_rw_d;
  end

  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign bubble_id_ex = stall;
  assign flush_if_id  = flush_if;
  assign flush_id_ex  = flush_id;
  assign flush_ex_mem = flush_ex;
  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit. Two instances share one stimulus
// stream: config 0 is the default (forwarding, BR_FLUSH=3, 16-bit counters);
// config 1 has no forwarding, BR_FLUSH=1 and 4-bit counters. A pipeline
// reference model predicts every cycle's outputs and queues them for a
// monitor that compares on the falling edge.
module tb_pipe_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic       redir;
  } in_t;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } stage_t;

  typedef struct packed {
    logic        stall;
    logic        fif;
    logic        fie;
    logic        fem;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
  } out_t;

  typedef struct packed {
    out_t e0;
    out_t e1;
  } rec_t;

  logic clk;
  logic rst_n;
  logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, redirect;
  logic [4:0] id_rs, id_rt, id_dst;

  logic s0_stall_pc, s0_stall_if_id, s0_bubble, s0_fif, s0_fie, s0_fem;
  logic [1:0] s0_fa, s0_fb;
  logic [15:0] s0_sc, s0_fc;
  logic s1_stall_pc, s1_stall_if_id, s1_bubble, s1_fif, s1_fie, s1_fem;
  logic [1:0] s1_fa, s1_fb;
  logic [3:0] s1_sc, s1_fc;

  int total = 0;
  int bad = 0;

  rec_t sb[$];

  // Reference model state, indexed by configuration; hist[c][d] is the
  // instruction d stages downstream of ID (1 = EX, 2 = MEM).
  stage_t hist [2][3];
  logic [1:0] fa_s [2];
  logic [1:0] fb_s [2];
  int sc_s [2];
  int fc_s [2];
  in_t cur;

  pipe_hazard_unit dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
    .stall_pc(s0_stall_pc), .stall_if_id(s0_stall_if_id), .bubble_id_ex(s0_bubble),
    .flush_if_id(s0_fif), .flush_id_ex(s0_fie), .flush_ex_mem(s0_fem),
    .fwd_a(s0_fa), .fwd_b(s0_fb), .stall_cnt(s0_sc), .flush_cnt(s0_fc)
  );

  pipe_hazard_unit #(.RA_W(5), .FWD_EN(0), .BR_FLUSH(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
    .stall_pc(s1_stall_pc), .stall_if_id(s1_stall_if_id), .bubble_id_ex(s1_bubble),
    .flush_if_id(s1_fif), .flush_id_ex(s1_fie), .flush_ex_mem(s1_fem),
    .fwd_a(s1_fa), .fwd_b(s1_fb), .stall_cnt(s1_sc), .flush_cnt(s1_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cfg_fwd(input int c);
    return (c == 0) ? 1 : 0;
  endfunction

  function automatic int cfg_br(input int c);
    return (c == 0) ? 3 : 1;
  endfunction

  function automatic int cfg_max(input int c);
    return (c == 0) ? 65535 : 15;
  endfunction

  function automatic logic hits(input stage_t s, input logic u, input logic [4:0] r);
    return s.v && s.rw && (s.dst != 5'd0) && u && (r == s.dst);
  endfunction

  // Nearest in-flight producer of a source, as a forwarding select.
  function automatic logic [1:0] fwd_pick(input int c, input logic u, input logic [4:0] r);
    for (int d = 1; d <= 2; d++)
      if (hits(hist[c][d], u, r)) return (d == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input int c);
    out_t o;
    logic hz;
    stage_t p;
    o = '0;
    hz = 1'b0;
    for (int d = 1; d <= 2; d++) begin
      p = hist[c][d];
      if (cur.v && (hits(p, cur.urs, cur.rs) || hits(p, cur.urt, cur.rt)) &&
          (cfg_fwd(c) == 0 || (d == 1 && p.mr)))
        hz = 1'b1;
    end
    if (rst_n) begin
      o.stall = hz && !cur.redir;
      o.fif   = cur.redir;
      o.fie   = cur.redir && (cfg_br(c) >= 2);
      o.fem   = cur.redir && (cfg_br(c) >= 3);
    end
    o.fa = fa_s[c];
    o.fb = fb_s[c];
    o.sc = 16'(sc_s[c]);
    o.fc = 16'(fc_s[c]);
    return o;
  endfunction

  // Advance the model across one clock edge using the inputs held at it.
  task automatic model_edge(input int c);
    out_t o;
    stage_t nx;
    if (!rst_n) begin
      hist[c][1] = '0;
      hist[c][2] = '0;
      fa_s[c] = 2'b00;
      fb_s[c] = 2'b00;
      sc_s[c] = 0;
      fc_s[c] = 0;
      return;
    end
    o = model_out(c);
    nx = (o.stall || o.fie) ? stage_t'(0) : {cur.v, cur.dst, cur.rw, cur.mr};
    if (o.stall || o.fie || cfg_fwd(c) == 0) begin
      fa_s[c] = 2'b00;
      fb_s[c] = 2'b00;
    end else begin
      fa_s[c] = fwd_pick(c, cur.urs, cur.rs);
      fb_s[c] = fwd_pick(c, cur.urt, cur.rt);
    end
    if (o.stall && sc_s[c] < cfg_max(c)) sc_s[c]++;
    if (cur.redir && fc_s[c] < cfg_max(c)) fc_s[c]++;
    hist[c][2] = o.fem ? stage_t'(0) : hist[c][1];
    hist[c][1] = nx;
  endtask

  function automatic in_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic [4:0] dst,
                             input logic rw, input logic mr, input logic redir);
    in_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
    x.dst = dst; x.rw = rw; x.mr = mr; x.redir = redir;
    return x;
  endfunction

  function automatic in_t rnd_in();
    in_t x;
    x.v     = 1'($urandom_range(0, 1));
    x.rs    = 5'($urandom_range(0, 3));
    x.rt    = 5'($urandom_range(0, 3));
    x.urs   = 1'($urandom_range(0, 1));
    x.urt   = 1'($urandom_range(0, 1));
    x.dst   = 5'($urandom_range(0, 3));
    x.rw    = 1'($urandom_range(0, 1));
    x.mr    = 1'($urandom_range(0, 1));
    x.redir = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  // One cycle: clock the model, then drive new inputs and queue the expectation.
  task automatic step(input in_t x, input logic r);
    rec_t rr;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    rst_n = r;
    cur = x;
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs; id_uses_rt = x.urt;
    id_dst = x.dst; id_reg_write = x.rw; id_mem_read = x.mr; redirect = x.redir;
    rr.e0 = model_out(0);
    rr.e1 = model_out(1);
    sb.push_back(rr);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        check("d0.stall_pc", s0_stall_pc, r.e0.stall);
        check("d0.stall_if_id", s0_stall_if_id, r.e0.stall);
        check("d0.bubble_id_ex", s0_bubble, r.e0.stall);
        check("d0.flush_if_id", s0_fif, r.e0.fif);
        check("d0.flush_id_ex", s0_fie, r.e0.fie);
        check("d0.flush_ex_mem", s0_fem, r.e0.fem);
        check("d0.fwd_a", s0_fa, r.e0.fa);
        check("d0.fwd_b", s0_fb, r.e0.fb);
        check("d0.stall_cnt", s0_sc, r.e0.sc);
        check("d0.flush_cnt", s0_fc, r.e0.fc);
        check("d1.stall_pc", s1_stall_pc, r.e1.stall);
        check("d1.stall_if_id", s1_stall_if_id, r.e1.stall);
        check("d1.bubble_id_ex", s1_bubble, r.e1.stall);
        check("d1.flush_if_id", s1_fif, r.e1.fif);
        check("d1.flush_id_ex", s1_fie, r.e1.fie);
        check("d1.flush_ex_mem", s1_fem, r.e1.fem);
        check("d1.fwd_a", s1_fa, r.e1.fa);
        check("d1.fwd_b", s1_fb, r.e1.fb);
        check("d1.stall_cnt", {12'd0, s1_sc}, r.e1.sc);
        check("d1.flush_cnt", {12'd0, s1_fc}, r.e1.fc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    in_t nop, lw8, add9, add3, sub4, ind6, addi0, add5, lw3, use3;
    nop   = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    lw8   = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    add9  = mk(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    add3  = mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    sub4  = mk(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    ind6  = mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    addi0 = mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    add5  = mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    lw3   = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    use3  = mk(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);

    rst_n = 1'b0;
    cur = nop;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_dst = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; redirect = 1'b0;
    for (int c = 0; c < 2; c++) begin
      hist[c][1] = '0; hist[c][2] = '0;
      fa_s[c] = 2'b00; fb_s[c] = 2'b00; sc_s[c] = 0; fc_s[c] = 0;
    end

    // Reset state.
    repeat (3) step(nop, 1'b0);

    // Load-use: the consumer stays in ID while it stalls.
    step(lw8, 1'b1);
    repeat (3) step(add9, 1'b1);
    repeat (3) step(nop, 1'b1);
    // Back-to-back ALU chain, then with one independent instruction between.
    step(add3, 1'b1); step(sub4, 1'b1); step(sub4, 1'b1); step(sub4, 1'b1);
    repeat (3) step(nop, 1'b1);
    step(add3, 1'b1); step(ind6, 1'b1); step(sub4, 1'b1); step(sub4, 1'b1);
    repeat (3) step(nop, 1'b1);
    // Register 0 never creates a dependency.
    step(addi0, 1'b1); step(add5, 1'b1);
    repeat (3) step(nop, 1'b1);
    // Redirect in the same cycle as a load-use hazard.
    step(lw8, 1'b1);
    add9.redir = 1'b1;
    step(add9, 1'b1);
    add9.redir = 1'b0;
    repeat (3) step(nop, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) step(rnd_in(), 1'b1);
    repeat (3) step(nop, 1'b1);

    // Accumulate enough stalls to saturate the 4-bit counter.
    for (int i = 0; i < 12; i++) begin
      step(lw3, 1'b1);
      repeat (3) step(use3, 1'b1);
    end

    // Reset while both instances are stalling.
    step(lw3, 1'b1);
    step(use3, 1'b1);
    @(negedge clk);
    #2;
    check("d1.stall_cnt_saturated", {28'd0, s1_sc}, 32'd15);
    check("d0.stall_before_reset", s0_stall_pc, 1'b1);
    check("d1.stall_before_reset", s1_stall_pc, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst.d0.ctrl", {s0_stall_pc, s0_stall_if_id, s0_bubble, s0_fif, s0_fie, s0_fem}, 6'd0);
    check("rst.d0.fwd", {s0_fa, s0_fb}, 4'd0);
    check("rst.d0.cnt", {s0_sc, s0_fc}, 32'd0);
    check("rst.d1.ctrl", {s1_stall_pc, s1_stall_if_id, s1_bubble, s1_fif, s1_fie, s1_fem}, 6'd0);
    check("rst.d1.fwd", {s1_fa, s1_fb}, 4'd0);
    check("rst.d1.cnt", {s1_sc, s1_fc}, 8'd0);
    repeat (2) step(use3, 1'b0);

    // Traffic after reset release.
    for (int i = 0; i < 200; i++) step(rnd_in(), 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It keeps a shadow copy of the destination register, reg-write, mem-read and valid bits for the EX, MEM and WB stages. From that state it produces:
- PC and IF/ID hold (stall) signals,
- ID/EX bubble insertion,
- per-buffer flushes on a taken branch or jump,
- registered EX-stage forwarding selects.

It also keeps saturating stall and flush performance counters. It lets the core run dependent instruction streams without software NOPs.

Parameters:
- RA_W, 5: register-address width.
- FWD_EN, 1: 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling.
- BR_FLUSH, 3: number of younger pipeline buffers squashed on redirect, 1..3 (3 = branch resolved in MEM).
- CNT_W, 16: performance-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  RA_W  source register 1 of the ID instruction.
- id_rt  in  RA_W  source register 2 of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_dst  in  RA_W  destination register of the ID instruction (after RegDst).
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- redirect  in  1  taken branch or jump resolved this cycle (MEM stage).
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold the IF/ID buffer.
- bubble_id_ex  out  1  load NOP controls into ID/EX.
- flush_if_id  out  1  clear IF/ID.
- flush_id_ex  out  1  clear ID/EX.
- flush_ex_mem  out  1  clear EX/MEM.
- fwd_a  out  2  EX operand A select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  number of stall cycles, saturating.
- flush_cnt  out  CNT_W  number of redirect events, saturating.

Behaviour:
Shadow state and reset
- Shadow stages S_EX, S_MEM, S_WB each hold {valid, dst, rw, mr}.
- Reset is asynchronous, effective immediately on rst_n low. It clears all shadow valid bits, fwd_a, fwd_b, stall_cnt and flush_cnt to 0.
- Reset must force every combinational output to 0. This includes asserting rst_n low in the middle of a stall.

Hazard term
- match(s) = s.valid & s.rw & (s.dst != 0) & ((id_uses_rs & id_rs == s.dst) | (id_uses_rt & id_rt == s.dst)).
- Register 0 never matches.

Hazard (combinational)
- FWD_EN=1: hz = id_valid & match(S_EX) & S_EX.mr (load-use).
- FWD_EN=0: hz = id_valid & (match(S_EX) | match(S_MEM)).
- S_WB never causes a hazard; the register file is write-first.
- stall = hz & ~redirect.
- stall_pc = stall_if_id = bubble_id_ex = stall.

Redirect (combinational)
- flush_if_id = redirect.
- flush_id_ex = redirect & (BR_FLUSH >= 2).
- flush_ex_mem = redirect & (BR_FLUSH >= 3).
- Redirect takes priority over stall: no stall is asserted in a redirect cycle.

Shadow update (every clock edge)
- S_EX <= (stall | flush_id_ex) ? invalid : {id_valid & ~flush_if_id_eff, id_dst, id_reg_write, id_mem_read}.
- flush_if_id_eff applies only when BR_FLUSH == 1. With BR_FLUSH == 1 the ID instruction itself survives, so this term must leave it valid.
- S_MEM <= flush_ex_mem ? invalid : S_EX.
- S_WB <= S_MEM.

Forwarding selects (registered)
- fwd_a and fwd_b are registered so that they align with the instruction that enters EX.
- For operand A (rs), evaluated at the edge:
  - 10 if S_EX would match rs;
  - else 01 if S_MEM would match rs;
  - else 00.
  - The younger producer wins.
- Operand B (rt) uses the same rule.
- fwd_a and fwd_b load 00 when stall, flush_id_ex or FWD_EN=0.

Counters
- stall_cnt increments once per cycle while stall is high.
- flush_cnt increments once per cycle while redirect is high.
- Both saturate at 2^CNT_W − 1 and never wrap.

Latency
- Stall, bubble and flush outputs: 0 cycles (combinational).
- Forwarding selects: 1 cycle.

Test Plan:
- Load-use, FWD_EN=1: lw r8 then add r9, r8, r1 (id_rs=8). Required: stall=1 for exactly 1 cycle; S_EX bubble inserted; on the next cycle the add is in EX with fwd_a=01, fwd_b=00; stall_cnt=1.
- ALU chain: add r3 followed immediately by sub r4, r3, r3. Required: no stall; fwd_a=fwd_b=10 one cycle after the sub leaves ID. Insert one independent instruction between them instead: fwd_a=01.
- Register 0: addi r0 then add r5, r0, r0. Required: no stall, fwd_a=fwd_b=00.
- Redirect with a simultaneous load-use hazard, BR_FLUSH=3. Required: stall=0, all three flushes=1, flush_cnt=1, stall_cnt unchanged; the next cycle S_EX and S_MEM are invalid.
- FWD_EN=0: add r3 then sub r4, r3, r2. Required: stall for 2 consecutive cycles, fwd always 00. Run the same case with BR_FLUSH=1 and redirect: only flush_if_id=1.
- CNT_W=4: hold a stall condition for 20 cycles (producer kept invalid). Required: stall_cnt saturates at 15. Then pull rst_n low mid-stall: every output goes to 0 immediately, with no clock edge needed.
